// File: rtl/div_pkg.sv
// Shared definitions for the DIV sequencer: state encoding, widths and the
// divide-by-zero quotient magnitude.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

  // Magnitude quotient produced when the divisor is zero (every trial succeeds).
  localparam logic [DIV_WIDTH-1:0] DIV_DBZ_QUO = '1;

endpackage

// File: rtl/div_step_32bit.sv
// One combinational restoring-division step: shift in the next dividend bit,
// try to subtract the divisor, keep the difference only if it did not borrow.
module div_step_32bit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             nbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             qbit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] sum;
  logic             unused_bits;

  // Shifted partial remainder is WIDTH+1 bits wide; the subtraction is an add
  // of the inverted, zero-extended divisor plus one. Carry out means no borrow.
  assign shifted  = {rem, nbit};
  assign sum      = {1'b0, shifted} + {1'b0, ~{1'b0, divisor}} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign qbit     = sum[WIDTH+1];
  assign rem_next = qbit ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];

  // Top bits are provably zero whenever they are selected.
  assign unused_bits = ^{sum[WIDTH], shifted[WIDTH]};

endmodule

// File: rtl/div_sequencer_32bit.sv
// Multi-cycle signed/unsigned restoring divider sequencer for the ALU DIV op.
// Quotient goes to LO, remainder to HI. Status outputs (busy, done) are
// registered from the current state, so they appear one cycle after it.
// Optional build macro DIV_EARLY_ZERO_EN: a zero divisor skips the iteration
// phase and jumps straight to FIX with the precomputed divide-by-zero result.
//
// Handshake: start is sampled only while in IDLE; once accepted the operands
// are captured and any further start is ignored until the unit is back in
// IDLE. done is a one-cycle pulse; LO, HI and dbz are valid with it and hold
// until the next accepted start (dbz clears on accept).
module div_sequencer_32bit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] Ra,
  input  logic [WIDTH-1:0] Rb,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] HI,
  output div_state_e       dbg_state
);

  localparam int                 CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_END = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   ONE     = WIDTH'(1);

  div_state_e       state;
  logic [WIDTH-1:0] ra_q, rb_q, quo, rem;
  logic             sgn_q, qneg, rneg;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] ra_mag, rb_mag, rem_next;
  logic             qbit;

  // Two's-complement magnitudes of the captured operands for signed divides.
  assign ra_mag = (sgn_q && ra_q[WIDTH-1]) ? (~ra_q + ONE) : ra_q;
  assign rb_mag = (sgn_q && rb_q[WIDTH-1]) ? (~rb_q + ONE) : rb_q;

  div_step_32bit #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .nbit     (quo[WIDTH-1]),
    .divisor  (rb_q),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  assign dbg_state = state;

  // Sequencer FSM with datapath registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      dbz   <= 1'b0;
      LO    <= '0;
      HI    <= '0;
      cnt   <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      sgn_q <= 1'b0;
      quo   <= '0;
      rem   <= '0;
      qneg  <= 1'b0;
      rneg  <= 1'b0;
    end else begin
      busy <= (state == PREP) || (state == ITER) || (state == FIX);
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            ra_q  <= Ra;
            rb_q  <= Rb;
            sgn_q <= sgn;
            dbz   <= 1'b0;
            state <= PREP;
          end
        end
        PREP: begin
          quo  <= ra_mag;
          rb_q <= rb_mag;
          qneg <= sgn_q & (ra_q[WIDTH-1] ^ rb_q[WIDTH-1]);
          rneg <= sgn_q & ra_q[WIDTH-1];
          dbz  <= (rb_q == '0);
          rem  <= '0;
          cnt  <= '0;
`ifdef DIV_EARLY_ZERO_EN
          if (rb_q == '0) begin
            quo   <= WIDTH'(DIV_DBZ_QUO);
            rem   <= ra_mag;
            state <= FIX;
          end else begin
            state <= ITER;
          end
`else
          state <= ITER;
`endif
        end
        ITER: begin
          rem <= rem_next;
          quo <= {quo[WIDTH-2:0], qbit};
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_END) state <= FIX;
        end
        FIX: begin
          LO    <= qneg ? (~quo + ONE) : quo;
          HI    <= rneg ? (~rem + ONE) : rem;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer_32bit.sv
// Directed-vector bench for div_sequencer_32bit. Edge 0 is the rising edge
// that samples start; outputs are sampled 1 time unit after each rising edge.
module tb_div_sequencer_32bit;
  import div_pkg::*;

  localparam int W = 32;

  // Clock and reset block
  logic clk = 1'b0;
  logic clr, start, sgn;
  logic [W-1:0] ra, rb;
  logic busy, done, dbz;
  logic [W-1:0] lo, hi;
  div_state_e dbg_state;

  always #5 clk = ~clk;

  div_sequencer_32bit dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .sgn       (sgn),
    .Ra        (ra),
    .Rb        (rb),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz),
    .LO        (lo),
    .HI        (hi),
    .dbg_state (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard check: every comparison goes through here.
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_lo;
    logic [W-1:0] exp_hi;
    logic         exp_dbz;
    bit           poke;
  } vec_t;

  // Driver: issue one divide, watch busy every cycle, return done latency.
  // With poke set, a second start (different operands) is sampled at edge 10.
  task automatic run_div(input vec_t v, output int lat, output int busy_bad);
    @(negedge clk);
    sgn = v.s; ra = v.a; rb = v.b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    busy_bad = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (v.poke && k == 9) begin
        start = 1'b1; ra = 32'h0000_0000; rb = 32'h0000_0001; sgn = 1'b1;
      end
      if (v.poke && k == 10) start = 1'b0;
      if (done) begin
        lat = k;
        if (busy) busy_bad++;
        break;
      end
      if (!busy) busy_bad++;
    end
  endtask

  vec_t vecs[7];
  int lat, busy_bad;

  initial begin
    vecs[0] = '{1'b1, 32'd100,        32'd7,        32'h0000_000E, 32'h0000_0002, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'd2,        32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'h0000_0005, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 32'hFFFF_FFFB,  32'd0,        32'h0000_0001, 32'hFFFF_FFFB, 1'b1, 1'b0};

    clr = 1'b1; start = 1'b0; sgn = 1'b0; ra = '0; rb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_dbz",   32'(dbz),  32'd0);
    check("rst_lo",    lo, 32'd0);
    check("rst_hi",    hi, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    clr = 1'b0;

    foreach (vecs[i]) begin
      run_div(vecs[i], lat, busy_bad);
`ifdef DIV_EARLY_ZERO_EN
      if (vecs[i].b == '0) check($sformatf("v%0d_lat_early", i), 32'(lat > 0 && lat <= 4), 32'd1);
      else                 check($sformatf("v%0d_lat", i), 32'(lat), 32'd35);
`else
      check($sformatf("v%0d_lat", i), 32'(lat), 32'd35);
`endif
      check($sformatf("v%0d_busy", i), 32'(busy_bad), 32'd0);
      check($sformatf("v%0d_lo", i),   lo, vecs[i].exp_lo);
      check($sformatf("v%0d_hi", i),   hi, vecs[i].exp_hi);
      check($sformatf("v%0d_dbz", i),  32'(dbz), 32'(vecs[i].exp_dbz));
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      check($sformatf("v%0d_lo_hold", i), lo, vecs[i].exp_lo);
    end

    // Abort mid-ITER with clr sampled at edge 12.
    @(negedge clk);
    sgn = 1'b1; ra = 32'd100; rb = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("abort_pre_state", 32'(dbg_state), 32'(ITER));
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    check("abort_busy",  32'(busy), 32'd0);
    check("abort_lo",    lo, 32'd0);
    check("abort_hi",    hi, 32'd0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    clr = 1'b0;

    run_div(vecs[0], lat, busy_bad);
    check("fresh_lat",  32'(lat), 32'd35);
    check("fresh_busy", 32'(busy_bad), 32'd0);
    check("fresh_lo",   lo, 32'h0000_000E);
    check("fresh_hi",   hi, 32'h0000_0002);
    check("fresh_dbz",  32'(dbz), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
